// File: rtl/byte_serial_add_seq.sv
// byte_serial_add_seq: drives an external combinational 8-bit adder one byte slice per clock,
// LSB first, chaining the adder's carry-out back in, and assembles an 8*WORDS-bit result.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake; in_a, in_b, in_cin sampled on accept
//   add_a, add_b, add_cin      slice presented to the adder (zero outside RUN)
//   add_sum, add_cout          adder response, combinational from add_a/add_b/add_cin
//   out_valid/out_ready        result handshake; out_sum, out_cout, out_ovf valid in DONE
module byte_serial_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] in_a,
  input  logic [8*WORDS-1:0] in_b,
  input  logic               in_cin,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  output logic               add_cin,
  input  logic [7:0]         add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] out_sum,
  output logic               out_cout,
  output logic               out_ovf
);

  localparam int unsigned W    = 8 * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            accept;

  // in_ready is held low while reset is asserted even though the state register reads IDLE.
  assign in_ready = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[8*int'(idx_q) +: 8] = add_sum;
        carry_d = add_cout;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          if (in_valid) begin
            // Back-to-back: the new operands replace the old ones on the same edge.
            a_d     = in_a;
            b_d     = in_b;
            carry_d = in_cin;
            idx_d   = '0;
            sum_d   = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    out_ovf   = 1'b0;
    if (state_q == StRun) begin
      add_a   = a_q[8*int'(idx_q) +: 8];
      add_b   = b_q[8*int'(idx_q) +: 8];
      add_cin = carry_q;
    end
    if (state_q == StDone) begin
      out_valid = 1'b1;
      out_sum   = sum_q;
      out_cout  = carry_q;
      // Carry into the MSB xor carry out of it.
      out_ovf   = a_q[W-1] ^ b_q[W-1] ^ sum_q[W-1] ^ carry_q;
    end
  end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
module tb_byte_serial_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Stand-in for the 8-bit adder the block is paired with.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  byte_serial_add_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = a[W-1] ^ b[W-1] ^ full[W-1] ^ full[W];
    q.push_back(e);
  endtask

  // Called one tick after a clock edge; accepts on the following edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    #1;
    check("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
    push_exp(a, b, cin);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    // Operands must only be sampled at accept.
    in_a      = ~a;
    in_b      = ~b;
    in_cin    = ~cin;
  endtask

  // Follows the adder ports through the RUN cycles using an independent ripple model.
  task automatic run_trace(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic       c;
    logic [8:0] t;
    c = cin;
    for (int i = 0; i < WORDS; i++) begin
      check("add_a", {56'd0, add_a}, {56'd0, a[8*i +: 8]});
      check("add_b", {56'd0, add_b}, {56'd0, b[8*i +: 8]});
      check("add_cin", {63'd0, add_cin}, {63'd0, c});
      check("out_valid_in_run", {63'd0, out_valid}, 64'd0);
      check("in_ready_in_run", {63'd0, in_ready}, 64'd0);
      t = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'h00, c};
      c = t[8];
      step();
    end
    check("out_valid_after_last_slice", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic check_result();
    exp_t e;
    if (q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = q.pop_front();
      check("out_sum", {32'd0, out_sum}, {32'd0, e.sum});
      check("out_cout", {63'd0, out_cout}, {63'd0, e.cout});
      check("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_release", {63'd0, out_valid}, 64'd0);
    check("add_a_idle", {56'd0, add_a}, 64'd0);
  endtask

  task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    start_op(a, b, cin);
    run_trace(a, b, cin);
    check_result();
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("rst_add_a", {56'd0, add_a}, 64'd0);
    check("rst_add_cin", {63'd0, add_cin}, 64'd0);
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Ignored out_ready while idle.
    out_ready = 1'b1;
    step();
    check("out_ready_idle_ignored", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    full_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    full_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    full_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    full_op(32'h8000_0000, 32'h8000_0000, 1'b0);

    // Backpressure then back-to-back accept.
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    run_trace(32'h1234_5678, 32'h1111_1111, 1'b0);
    check_result();
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_out_sum", {32'd0, out_sum}, 64'h2345_6789);
      check("bp_out_cout", {63'd0, out_cout}, 64'd0);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
    run_trace(32'h0000_0010, 32'h0000_0020, 1'b0);
    check_result();
    release_result();

    full_op(32'h0403_0201, 32'h4030_2010, 1'b0);
    full_op(32'h80FF_FF80, 32'h7F00_0180, 1'b1);

    // Reset mid-operation.
    start_op(32'hAAAA_5555, 32'h5555_AAAB, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_add_a", {56'd0, add_a}, 64'd0);
    check("midrst_add_b", {56'd0, add_b}, 64'd0);
    check("midrst_add_cin", {63'd0, add_cin}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    check("midrst_in_ready_after", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      check("no_stale_result", {63'd0, out_valid}, 64'd0);
      step();
    end
    full_op(32'h0000_0001, 32'h0000_0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/byte_serial_add_seq.md
Name: byte_serial_add_seq

Overview:
- Sequencer that sits directly upstream and downstream of the team's 8-bit carry-bypass adder.
- Feeds the adder one byte slice per clock, LSB first, and chains the adder's carry-out back in as the next slice's carry-in.
- Collects the sum slices into a wide result with a valid/ready handshake on both sides.
- Lets the combinational 8-bit adder perform 8*WORDS-bit additions in a multi-cycle fashion.

Parameters:
- WORDS, 4, number of 8-bit slices; operand width W = 8*WORDS, WORDS >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  initial carry-in.
- add_a  output  8  slice of A to the adder.
- add_b  output  8  slice of B to the adder.
- add_cin  output  1  carry to the adder.
- add_sum  input  8  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  wide sum.
- out_cout  output  1  final carry-out.
- out_ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset, while rst_n is low and asynchronously:
  - state = IDLE; idx = 0; carry register = 0.
  - Operand and result registers cleared.
  - out_valid = 0; out_sum = 0; out_cout = 0; out_ovf = 0.
  - add_a = 0; add_b = 0; add_cin = 0.
  - in_ready = 0 while reset is asserted, 1 from the first cycle after release.
- Reset mid-operation aborts the operation. The partial result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_a, in_b; carry register <= in_cin; idx <= 0; go to RUN.
- RUN:
  - add_a = A byte idx; add_b = B byte idx; add_cin = carry register.
  - Each edge: result byte idx <= add_sum; carry register <= add_cout.
  - If idx == WORDS-1, go to DONE; else idx <= idx+1.
  - in_ready = 0.
- Outside RUN: add_a, add_b and add_cin are driven 0.
- DONE:
  - out_valid = 1.
  - out_sum = assembled result; out_cout = carry register.
  - out_ovf = A[W-1] ^ B[W-1] ^ sum[W-1] ^ out_cout, i.e. the carry into the MSB xor the carry out of it.
  - Outputs are registered and stay stable while out_valid=1 and out_ready=0.
- DONE exit:
  - in_ready = out_ready.
  - On out_ready & in_valid: accept new operands and go directly to RUN (back-to-back operation).
  - On out_ready & !in_valid: go to IDLE.
- Latency: the accept edge is E0. Slices are captured at edges E1..E_WORDS. out_valid rises after edge E_WORDS.
- Sustained throughput: one operation per WORDS+1 cycles.
- Inputs: in_a/in_b/in_cin are sampled only at accept. Changes afterwards do not affect the operation in flight.
- Handshake signals:
  - in_valid without acceptance has no effect.
  - out_ready while out_valid=0 is ignored.
- Arithmetic: unsigned modulo 2^W sum; the carry chain is exactly the adder's. The block adds no internal arithmetic beyond the overflow XOR.

Test Plan:
1. WORDS=4, in_a=0x000000FF, in_b=0x00000001, cin=0, accept at E0 -> out_valid after E4; out_sum=0x00000100, cout=0, ovf=0.
2. Full ripple: 0xFFFFFFFF + 0x00000000 with cin=1 -> out_sum=0x00000000, cout=1, ovf=0. add_cin=1 in every RUN cycle.
3. Signed overflow:
   - 0x7FFFFFFF + 0x00000001 -> 0x80000000, cout=0, ovf=1.
   - 0x80000000 + 0x80000000 -> 0x00000000, cout=1, ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and out_* stay stable, in_ready=0. Then assert out_ready with in_valid and new operands 0x00000010 + 0x00000020 -> back-to-back accept; out_valid=0 for the 4 RUN cycles, then 0x00000030.
5. Port trace: monitor the adder ports for 0x04030201 + 0x40302010 -> add_a/add_b sequence (01,10), (02,20), (03,30), (04,40). add_cin in each cycle equals the previous cycle's add_cout.
6. Reset: drop rst_n after the 2nd RUN cycle -> immediately out_valid=0 and add_*=0. After release, in_ready=1 and no stale result appears. A fresh 0x00000001 + 0x00000001 yields 0x00000002.
